// File: rtl/cw_pkg.sv
// Shared constant-weight code definitions: geometry, state encoding and the Golomb
// parameter rule used by both the encoder and the decoder.
package cw_pkg;
   localparam int N    = 2048;
   localparam int T    = 10;
   localparam int CW_W = 11;
   localparam int NR_W = 12;
   localparam int TR_W = 4;
   localparam int D_W  = 4;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT_CW = 3'd1;
   localparam logic [2:0] S_UNARY   = 3'd2;
   localparam logic [2:0] S_BINARY  = 3'd3;
   localparam logic [2:0] S_FLUSH   = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   function automatic logic [D_W-1:0] msb_idx(input logic [NR_W-1:0] v);
      logic [D_W-1:0] r;
      r = '0;
      for (int i = 0; i < NR_W; i++) begin
         if (v[i]) r = D_W'(i);
      end
      return r;
   endfunction

   // Number of binary remainder bits for the next gap.
   function automatic logic [D_W-1:0] golomb_d(input logic [NR_W-1:0] n_rem,
                                               input logic [TR_W-1:0] t_rem);
      logic [D_W-1:0] mn;
      logic [D_W-1:0] mt;
      mn = msb_idx(n_rem);
      mt = msb_idx({{(NR_W-TR_W){1'b0}}, t_rem});
      return (mn > mt) ? (mn - mt) : '0;
   endfunction
endpackage

// File: rtl/cw_bit_packer_1to8.sv
// Serial-to-byte packer: collects bits MSB-first and presents each byte on a
// valid/ready output; flush pads a partial byte with zeros in the LSBs.
module cw_bit_packer_1to8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic       bit_ready,
   input  logic       flush,
   output logic       empty,
   output logic [7:0] msg_byte,
   output logic       msg_valid,
   input  logic       msg_ready
);
   logic [7:0] shift_reg;
   logic [3:0] count_reg;
   logic [7:0] byte_reg;
   logic       valid_reg;
   logic       slot_free;

   assign slot_free = !valid_reg || msg_ready;
   assign bit_ready = slot_free;
   assign empty     = (count_reg == 4'd0);
   assign msg_byte  = byte_reg;
   assign msg_valid = valid_reg;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         shift_reg <= '0;
         count_reg <= '0;
         byte_reg  <= '0;
         valid_reg <= 1'b0;
      end else begin
         if (valid_reg && msg_ready) valid_reg <= 1'b0;
         if (bit_valid && slot_free) begin
            if (count_reg == 4'd7) begin
               byte_reg  <= {shift_reg[6:0], bit_in};
               valid_reg <= 1'b1;
               count_reg <= '0;
            end else begin
               shift_reg <= {shift_reg[6:0], bit_in};
               count_reg <= count_reg + 4'd1;
            end
         end else if (flush && (count_reg != 4'd0) && slot_free) begin
            // Only the low count_reg bits are live; shifting pushes stale bits out the top.
            byte_reg  <= shift_reg << (4'd8 - count_reg);
            valid_reg <= 1'b1;
            count_reg <= '0;
         end
      end
   end
endmodule

// File: rtl/cw_decoder_main.sv
// Constant-weight decoder: turns T increasing nonzero positions back into the
// Golomb-coded message bit stream and packs it into bytes.
module cw_decoder_main
   import cw_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [CW_W-1:0] cw_word,
   input  logic            cw_valid,
   output logic            cw_ready,
   output logic [7:0]      msg_byte,
   output logic            msg_valid,
   input  logic            msg_ready,
   output logic            msg_done,
   output logic            err
);
   logic [2:0]      state_reg;
   logic [NR_W-1:0] prev_pos_reg;
   logic [NR_W-1:0] n_rem_reg;
   logic [NR_W-1:0] delta_reg;
   logic [NR_W-1:0] q_reg;
   logic [TR_W-1:0] t_rem_reg;
   logic [D_W-1:0]  d_reg;
   logic [D_W-1:0]  bit_idx_reg;
   logic            err_reg;

   logic [NR_W-1:0] delta_w;
   logic [NR_W-1:0] q_w;
   logic [D_W-1:0]  d_w;
   logic            accept;
   logic            bad_word;
   logic            bit_valid;
   logic            bit_in;
   logic            bit_ready;
   logic            bit_step;
   logic            pk_flush;
   logic            pk_clear;
   logic            pk_empty;

   always_comb begin
      cw_ready  = (state_reg == S_WAIT_CW);
      accept    = cw_valid && cw_ready;
      // prev_pos of all-ones stands for -1, so the first gap is simply the position.
      delta_w   = {1'b0, cw_word} - prev_pos_reg - 12'd1;
      d_w       = golomb_d(n_rem_reg, t_rem_reg);
      q_w       = delta_w >> d_w;
      bad_word  = ($signed({1'b0, cw_word}) <= $signed(prev_pos_reg)) ||
                  (({1'b0, delta_w} + 13'd1) > {1'b0, n_rem_reg}) ||
                  (q_w > n_rem_reg);
      bit_valid = (state_reg == S_UNARY) || (state_reg == S_BINARY);
      bit_in    = (state_reg == S_UNARY) ? (q_reg != '0) : delta_reg[bit_idx_reg];
      bit_step  = bit_valid && bit_ready;
      pk_flush  = (state_reg == S_FLUSH);
      pk_clear  = accept && bad_word;
      msg_done  = ((state_reg == S_FLUSH) || (state_reg == S_DONE)) &&
                  pk_empty && msg_valid && msg_ready;
      err       = err_reg;
   end

   cw_bit_packer_1to8 u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (pk_clear),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .flush     (pk_flush),
      .empty     (pk_empty),
      .msg_byte  (msg_byte),
      .msg_valid (msg_valid),
      .msg_ready (msg_ready)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         prev_pos_reg <= '1;
         n_rem_reg    <= NR_W'(N);
         t_rem_reg    <= TR_W'(T);
         delta_reg    <= '0;
         q_reg        <= '0;
         d_reg        <= '0;
         bit_idx_reg  <= '0;
         err_reg      <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_reg    <= S_WAIT_CW;
                  prev_pos_reg <= '1;
                  n_rem_reg    <= NR_W'(N);
                  t_rem_reg    <= TR_W'(T);
                  err_reg      <= 1'b0;
               end
            end
            S_WAIT_CW: begin
               if (accept) begin
                  if (bad_word) begin
                     state_reg <= S_IDLE;
                     err_reg   <= 1'b1;
                  end else begin
                     delta_reg    <= delta_w;
                     q_reg        <= q_w;
                     d_reg        <= d_w;
                     n_rem_reg    <= n_rem_reg - delta_w - 12'd1;
                     t_rem_reg    <= t_rem_reg - 4'd1;
                     prev_pos_reg <= {1'b0, cw_word};
                     state_reg    <= S_UNARY;
                  end
               end
            end
            S_UNARY: begin
               if (bit_step) begin
                  if (q_reg != '0) begin
                     q_reg <= q_reg - 12'd1;
                  end else if (d_reg == '0) begin
                     state_reg <= (t_rem_reg == '0) ? S_FLUSH : S_WAIT_CW;
                  end else begin
                     bit_idx_reg <= d_reg - 4'd1;
                     state_reg   <= S_BINARY;
                  end
               end
            end
            S_BINARY: begin
               if (bit_step) begin
                  if (bit_idx_reg == '0) begin
                     state_reg <= (t_rem_reg == '0) ? S_FLUSH : S_WAIT_CW;
                  end else begin
                     bit_idx_reg <= bit_idx_reg - 4'd1;
                  end
               end
            end
            S_FLUSH: begin
               // The final byte may already be handed over while still in FLUSH.
               if (pk_empty) state_reg <= (msg_done || !msg_valid) ? S_IDLE : S_DONE;
            end
            S_DONE: begin
               if (msg_done || !msg_valid) state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule
